// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
//   state_e       - control FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand/result width
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit subtract cell, d = a - b - bi.
//   a, b  - operand bits
//   bi    - borrow in
//   d     - difference bit
//   bout  - borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bi;
  assign bout = (~a & b) | (b & bi) | (~a & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial (LSB first) unsigned subtractor,
// diff = (a - b - bin) mod 2^WIDTH, one bit per clock.
//   clk, rst           - clock, asynchronous active-high reset
//   start              - request; sampled only while ready
//   a, b, bin          - minuend, subtrahend, borrow-in (captured on accept)
//   ready / busy / done- IDLE / RUN / DONE status (done is a 1-cycle pulse)
//   diff, bout         - result and MSB borrow of the last completed op
//   ovf                - signed overflow of the last completed op, present
//                        only when SERIAL_SUB_OVF_EN is defined
// Timing: accept at E0, bits processed at E1..E_WIDTH, done for one cycle,
// then back to IDLE.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int IDX_W = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
    $error("serial_subtractor: WIDTH must be 2..32");
  end

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic             borrow;
  logic [IDX_W-1:0] idx;
  logic             last_bit;
  logic             accept;
  logic             d_bit, bo_bit;

  full_subtractor u_fs (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bi  (borrow),
    .d   (d_bit),
    .bout(bo_bit)
  );

  assign last_bit = (idx == IDX_W'(WIDTH - 1));
  assign accept   = (state == IDLE) && start;
  // New bit enters from the MSB side; after WIDTH shifts bit 0 lands at LSB.
  assign res_nxt  = WIDTH'({d_bit, res_sh} >> 1);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- serial datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      borrow <= bin;
      idx    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      borrow <= bo_bit;
      // Wrap to 0 on the last bit so idx never reaches WIDTH.
      idx    <= last_bit ? '0 : idx + IDX_W'(1);
      // Result is published only once complete; partial bits stay internal.
      if (last_bit) begin
        diff <= res_nxt;
        bout <= bo_bit;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Two's-complement overflow: borrow into MSB differs from borrow out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ovf <= 1'b0;
    else if (state == RUN && last_bit) ovf <= borrow ^ bo_bit;
  end
`endif

  // ---------------- invariants ----------------
  idx_range_a: assert property (@(posedge clk) disable iff (rst)
    idx <= IDX_W'(WIDTH - 1));
  status_a: assert property (@(posedge clk) disable iff (rst)
    $onehot({ready, busy, done}));

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed + randomized bench for serial_subtractor.
// Two instances (WIDTH=8 and WIDTH=2) share clock and reset; an arithmetic
// reference model predicts status and results for both every cycle.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       st8, bi8, rdy8, bsy8, dn8, bo8;
  logic [7:0] a8, b8, d8;
  logic       st2, bi2, rdy2, bsy2, dn2, bo2;
  logic [1:0] a2, b2, d2;
`ifdef SERIAL_SUB_OVF_EN
  logic       ov8, ov2;
`endif

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .bin(bi8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .diff(d8), .bout(bo8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ov8)
`endif
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .bin(bi2),
    .ready(rdy2), .busy(bsy2), .done(dn2), .diff(d2), .bout(bo2)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ov2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // p: 0 = idle, 1..w = bit-cycles in flight, w+1 = completion cycle.
  typedef struct {
    int          p;
    logic [31:0] ca, cb;
    logic        cbi;
    logic [31:0] d;
    logic        bo, ov;
  } mdl_t;

  mdl_t m8 = '{default: 0};
  mdl_t m2 = '{default: 0};

  function automatic mdl_t mstep(mdl_t m, int w, logic st, logic [31:0] a, logic [31:0] b, logic bi);
    longint full, sa, sb, r, half;
    half = longint'(1) << (w - 1);
    if (m.p == 0) begin
      if (st) begin
        m.p = 1; m.ca = a; m.cb = b; m.cbi = bi;
      end
    end else if (m.p <= w) begin
      m.p++;
      if (m.p == w + 1) begin
        full = longint'(m.ca) - longint'(m.cb) - longint'(m.cbi);
        m.d  = 32'(full & ((longint'(1) << w) - 1));
        m.bo = (full < 0);
        sa   = (longint'(m.ca) >= half) ? longint'(m.ca) - 2 * half : longint'(m.ca);
        sb   = (longint'(m.cb) >= half) ? longint'(m.cb) - 2 * half : longint'(m.cb);
        r    = sa - sb - longint'(m.cbi);
        m.ov = (r < -half) || (r > half - 1);
      end
    end else begin
      m.p = 0;
    end
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8 <= '{default: 0};
      m2 <= '{default: 0};
    end else begin
      m8 <= mstep(m8, 8, st8, 32'(a8), 32'(b8), bi8);
      m2 <= mstep(m2, 2, st2, 32'(a2), 32'(b2), bi2);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ready8", 32'(rdy8), 32'(m8.p == 0));
    chk("busy8",  32'(bsy8), 32'(m8.p >= 1 && m8.p <= 8));
    chk("done8",  32'(dn8),  32'(m8.p == 9));
    chk("diff8",  32'(d8),   m8.d);
    chk("bout8",  32'(bo8),  32'(m8.bo));
    chk("ready2", 32'(rdy2), 32'(m2.p == 0));
    chk("busy2",  32'(bsy2), 32'(m2.p >= 1 && m2.p <= 2));
    chk("done2",  32'(dn2),  32'(m2.p == 3));
    chk("diff2",  32'(d2),   m2.d);
    chk("bout2",  32'(bo2),  32'(m2.bo));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf8",   32'(ov8),  32'(m8.ov));
    chk("ovf2",   32'(ov2),  32'(m2.ov));
`endif
  end

  // ---------------- directed helpers ----------------
  // Count negedges after E0 until done (bounded); caller is at a negedge.
  task automatic wait_done8(output int k);
    k = 1;
    while (!dn8 && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic eb, input string nm);
    int k;
    st8 = 1'b1; a8 = a; b8 = b; bi8 = bi;
    @(negedge clk);
    // Scramble inputs after accept: captured operands must not follow.
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
    wait_done8(k);
    chk({"lat_", nm}, 32'(k), 32'd9);
    chk({"diff_", nm}, 32'(d8), 32'(ed));
    chk({"bout_", nm}, 32'(bo8), 32'(eb));
    chk({"model_", nm}, m8.d, 32'(ed));
    @(negedge clk);
  endtask

  initial begin
    int k, dn_cnt, prev, n;
    rst = 1'b1;
    st8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    st2 = 0; a2 = 0; b2 = 0; bi2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy8), 32'd1);
    chk("rst_busy",  32'(bsy8), 32'd0);
    chk("rst_done",  32'(dn8),  32'd0);
    chk("rst_diff",  32'(d8),   32'd0);
    chk("rst_bout",  32'(bo8),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "05_03");
    run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "03_05");
    run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "00_00_b1");
    run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "80_01");
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf_80_01", 32'(ov8), 32'd1);
`endif

    // Start retriggered with new operands mid-run must be ignored.
    st8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bi8 = 1'b0;
    @(negedge clk);
    st8 = 1'b0; dn_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) begin st8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; end
      if (dn8) begin
        dn_cnt++;
        chk("ign_diff", 32'(d8), 32'h0F);
        st8 = 1'b0;
      end
      @(negedge clk);
    end
    st8 = 1'b0;
    chk("ign_done_cnt", 32'(dn_cnt), 32'd1);
    chk("ign_diff_hold", 32'(d8), 32'h0F);

    // Reset in the middle of a run.
    st8 = 1'b1; a8 = 8'h55; b8 = 8'h22;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(rdy8), 32'd1);
    chk("mid_rst_busy",  32'(bsy8), 32'd0);
    chk("mid_rst_done",  32'(dn8),  32'd0);
    chk("mid_rst_diff",  32'(d8),   32'd0);
    a8 = 8'hFF; b8 = 8'h0F; bi8 = 1'b0; st8 = 1'b1;
    dn_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (dn8) dn_cnt++;
    end
    chk("mid_rst_no_done", 32'(dn_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("first_edge_accept", 32'(bsy8), 32'd1);
    @(negedge clk);
    st8 = 1'b0;
    wait_done8(k);
    chk("lat_ff_0f", 32'(k), 32'd9);
    chk("diff_ff_0f", 32'(d8), 32'hF0);
    chk("bout_ff_0f", 32'(bo8), 32'd0);
    @(negedge clk);

    // WIDTH=2, start held high: one acceptance every 4 cycles.
    st2 = 1'b1; a2 = 2'd3; b2 = 2'd1; bi2 = 1'b0;
    prev = -1; n = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (dn2) begin
        if (n == 0) begin
          chk("w2_diff_3_1", 32'(d2), 32'd2);
          chk("w2_bout_3_1", 32'(bo2), 32'd0);
          a2 = 2'd1; b2 = 2'd3;
        end else begin
          chk("w2_period", 32'(i - prev), 32'd4);
          chk("w2_diff_1_3", 32'(d2), 32'd2);
          chk("w2_bout_1_3", 32'(bo2), 32'd1);
        end
        prev = i; n++;
      end
    end
    chk("w2_done_cnt", 32'(n), 32'd4);
    st2 = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized traffic on both instances; the model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      st8 = ($urandom_range(0, 3) == 0);
      a8  = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      st2 = ($urandom_range(0, 2) == 0);
      a2  = 2'($urandom); b2 = 2'($urandom); bi2 = 1'($urandom);
      @(negedge clk);
    end
    st8 = 1'b0; st2 = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
